nios_cpu_debug_vjtag_host: RTL and testbench

//   Host-side initiator for the Nios II debug slave's virtual-JTAG interface.

---
 rtl/nios_cpu_debug_vjtag_host_if.sv | 25 ++
 rtl/nios_cpu_debug_vjtag_host.sv | 184 ++++++++++++++++++
 tb/tb_nios_cpu_debug_vjtag_host.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nios_cpu_debug_vjtag_host_if.sv
// Command/response handshake bundle between a debug test master and the
// virtual-JTAG host initiator.
interface nios_cpu_debug_vjtag_host_if #(
  parameter int unsigned SHIFT_LEN = 38,
  parameter int unsigned IR_WIDTH  = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [IR_WIDTH-1:0]  cmd_ir;
  logic [SHIFT_LEN-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [SHIFT_LEN-1:0] rsp_data;
  logic [IR_WIDTH-1:0]  rsp_ir;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir
  );
endinterface

// File: rtl/nios_cpu_debug_vjtag_host.sv
// Host-side virtual-JTAG initiator: runs one UIR/CDR/SDR/UDR/RTI sequence per
// command with a clk-derived TCK and returns the word captured from TDO.
module nios_cpu_debug_vjtag_host #(
  parameter int unsigned TCK_DIV     = 4,
  parameter int unsigned SHIFT_LEN   = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned RTI_PERIODS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  nios_cpu_debug_vjtag_host_if.slave host,
  output logic                       busy,
  output logic                       vjh_tck,
  output logic                       vjh_tdi,
  input  logic                       vjh_tdo,
  output logic [IR_WIDTH-1:0]        vjh_ir_in,
  input  logic [IR_WIDTH-1:0]        vjh_ir_out,
  output logic                       vjh_uir,
  output logic                       vjh_cdr,
  output logic                       vjh_sdr,
  output logic                       vjh_udr,
  output logic                       vjh_rti
);
  localparam int unsigned TICK_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int unsigned CNT_MAX = (SHIFT_LEN > RTI_PERIODS) ? SHIFT_LEN : RTI_PERIODS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SHIFT_LEN-1:0] sr_q, sr_d, rsp_data_d;
  logic [IR_WIDTH-1:0]  ir_in_d, rsp_ir_d;
  logic                 tck_d, tdi_d, uir_d, cdr_d, sdr_d, udr_d, rti_d;
  logic                 cmd_ready_d, rsp_valid_d, busy_d;
  logic                 tick_term, rise, fall;

  assign tick_term = (tick_q == TICK_W'(TCK_DIV - 1));
  assign rise      = tick_term & ~vjh_tck;
  assign fall      = tick_term & vjh_tck;

  // Next-state and next-output logic; every state change lands on a TCK fall.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rsp_data_d  = host.rsp_data;
    rsp_ir_d    = host.rsp_ir;
    ir_in_d     = vjh_ir_in;
    tck_d       = vjh_tck;
    tdi_d       = vjh_tdi;
    uir_d       = vjh_uir;
    cdr_d       = vjh_cdr;
    sdr_d       = vjh_sdr;
    udr_d       = vjh_udr;
    rti_d       = vjh_rti;
    cmd_ready_d = host.cmd_ready;
    rsp_valid_d = host.rsp_valid;
    busy_d      = busy;

    if (state_q != S_IDLE && state_q != S_RSP) begin
      tick_d = tick_term ? '0 : tick_q + TICK_W'(1);
      tck_d  = tick_term ? ~vjh_tck : vjh_tck;
    end

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid && host.cmd_ready) begin
          state_d     = S_UIR;
          sr_d        = host.cmd_data;
          ir_in_d     = host.cmd_ir;
          uir_d       = 1'b1;
          rti_d       = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          tick_d      = '0;
          tck_d       = 1'b0;
        end
      end
      S_UIR: begin
        if (rise) rsp_ir_d = vjh_ir_out;
        if (fall) begin
          state_d = S_CDR;
          uir_d   = 1'b0;
          cdr_d   = 1'b1;
        end
      end
      S_CDR: begin
        if (fall) begin
          state_d = S_SDR;
          cdr_d   = 1'b0;
          sdr_d   = 1'b1;
          tdi_d   = sr_q[0];
          cnt_d   = '0;
        end
      end
      S_SDR: begin
        // Capture TDO on the rise, present the next TDI bit on the fall.
        if (rise) sr_d = {vjh_tdo, sr_q[SHIFT_LEN-1:1]};
        if (fall) begin
          if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
            state_d = S_UDR;
            sdr_d   = 1'b0;
            udr_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            tdi_d = sr_q[0];
          end
        end
      end
      S_UDR: begin
        if (fall) begin
          state_d = S_RTI;
          udr_d   = 1'b0;
          rti_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RTI: begin
        if (fall) begin
          if (cnt_q == CNT_W'(RTI_PERIODS - 1)) begin
            state_d     = S_RSP;
            rsp_data_d  = sr_q;
            rsp_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RSP: begin
        if (host.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      cnt_q          <= '0;
      sr_q           <= '0;
      host.rsp_data  <= '0;
      host.rsp_ir    <= '0;
      host.cmd_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      busy           <= 1'b0;
      vjh_ir_in      <= '0;
      vjh_tck        <= 1'b0;
      vjh_tdi        <= 1'b0;
      vjh_uir        <= 1'b0;
      vjh_cdr        <= 1'b0;
      vjh_sdr        <= 1'b0;
      vjh_udr        <= 1'b0;
      vjh_rti        <= 1'b1;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      cnt_q          <= cnt_d;
      sr_q           <= sr_d;
      host.rsp_data  <= rsp_data_d;
      host.rsp_ir    <= rsp_ir_d;
      host.cmd_ready <= cmd_ready_d;
      host.rsp_valid <= rsp_valid_d;
      busy           <= busy_d;
      vjh_ir_in      <= ir_in_d;
      vjh_tck        <= tck_d;
      vjh_tdi        <= tdi_d;
      vjh_uir        <= uir_d;
      vjh_cdr        <= cdr_d;
      vjh_sdr        <= sdr_d;
      vjh_udr        <= udr_d;
      vjh_rti        <= rti_d;
    end
  end
endmodule

// File: tb/tb_nios_cpu_debug_vjtag_host.sv
// Bench for nios_cpu_debug_vjtag_host: loopback vJTAG slave, period-arithmetic
// reference model checked every cycle, and directed transactions.
module tb_nios_cpu_debug_vjtag_host;
  localparam int unsigned D     = 2;
  localparam int unsigned L     = 38;
  localparam int unsigned IRW   = 2;
  localparam int unsigned RTIP  = 4;
  localparam int unsigned PER   = 2 * D;
  localparam int unsigned TOTAL = PER * (3 + L + RTIP);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, vjh_tck, vjh_tdi, vjh_tdo;
  logic [IRW-1:0] vjh_ir_in;
  logic [IRW-1:0] vjh_ir_out = '0;
  logic vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti;

  int n_tests = 0;
  int n_fail  = 0;

  nios_cpu_debug_vjtag_host_if #(.SHIFT_LEN(L), .IR_WIDTH(IRW)) bus ();

  nios_cpu_debug_vjtag_host #(.TCK_DIV(D), .SHIFT_LEN(L), .IR_WIDTH(IRW), .RTI_PERIODS(RTIP)) dut (
    .clk(clk), .reset(reset), .host(bus), .busy(busy),
    .vjh_tck(vjh_tck), .vjh_tdi(vjh_tdi), .vjh_tdo(vjh_tdo),
    .vjh_ir_in(vjh_ir_in), .vjh_ir_out(vjh_ir_out),
    .vjh_uir(vjh_uir), .vjh_cdr(vjh_cdr), .vjh_sdr(vjh_sdr),
    .vjh_udr(vjh_udr), .vjh_rti(vjh_rti)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loopback slave: captures slave_cap in CDR, shifts TDI in during SDR.
  logic [L-1:0] slave_cap = '0;
  logic [L-1:0] s_sr = '0;
  logic [L-1:0] udr_val = '0;
  int udr_cnt = 0;
  assign vjh_tdo = s_sr[0];
  always @(posedge vjh_tck) begin
    if (vjh_cdr) s_sr <= slave_cap;
    else if (vjh_sdr) s_sr <= {vjh_tdi, s_sr[L-1:1]};
    if (vjh_udr) begin
      udr_cnt <= udr_cnt + 1;
      udr_val <= s_sr;
    end
  end

  // Reference model: position inside a transaction measured in clk since accept.
  logic           m_busy = 1'b0;
  int             m_n = 0;
  logic [IRW-1:0] m_ir = '0, m_irout = '0, m_rsp_ir = '0;
  logic [L-1:0]   m_data = '0, m_cap = '0, m_rsp = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_n <= 0; m_ir <= '0; m_rsp <= '0; m_rsp_ir <= '0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy <= 1'b1; m_n <= 0; m_ir <= bus.cmd_ir; m_data <= bus.cmd_data;
        m_cap <= slave_cap; m_irout <= vjh_ir_out;
      end
    end else if (m_n < int'(TOTAL)) begin
      m_n <= m_n + 1;
      if (m_n == int'(TOTAL) - 1) begin
        m_rsp <= m_cap; m_rsp_ir <= m_irout;
      end
    end else if (bus.rsp_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    int p;
    logic [4:0] e_str;
    logic e_tck, e_tdi, e_valid;
    if (!reset) begin
      e_valid = m_busy && (m_n == int'(TOTAL));
      e_tck = 1'b0; e_tdi = 1'b0; e_str = 5'b00001;
      if (m_busy && m_n < int'(TOTAL)) begin
        p = m_n / int'(PER);
        e_tck = ((m_n / int'(D)) % 2) == 1;
        if (p == 0) e_str = 5'b10000;
        else if (p == 1) e_str = 5'b01000;
        else if (p < int'(L) + 2) begin
          e_str = 5'b00100;
          e_tdi = m_data[p-2];
        end else if (p == int'(L) + 2) e_str = 5'b00010;
      end
      chk("strobes", {vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti}, e_str);
      chk("tck", vjh_tck, e_tck);
      chk("tdi", vjh_tdi, e_tdi);
      chk("cmd_ready", bus.cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("rsp_valid", bus.rsp_valid, e_valid);
      chk("ir_in", vjh_ir_in, m_ir);
      chk("rsp_data", bus.rsp_data, m_rsp);
      if (!m_busy || e_valid) chk("rsp_ir", bus.rsp_ir, m_rsp_ir);
    end
  end

  // Strobe duration and accept counters.
  int c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, acc_cnt = 0;
  always @(negedge clk) if (!reset) begin
    c_uir += int'(vjh_uir); c_cdr += int'(vjh_cdr);
    c_sdr += int'(vjh_sdr); c_udr += int'(vjh_udr);
  end
  always @(posedge clk) if (!reset && bus.cmd_valid && bus.cmd_ready) acc_cnt++;

  task automatic do_txn(input logic [IRW-1:0] ir, input logic [L-1:0] data,
                        input logic [IRW-1:0] irout, input logic [L-1:0] cap,
                        input bit hold_valid, input int stall);
    int n, u0;
    @(negedge clk);
    vjh_ir_out = irout; slave_cap = cap;
    bus.cmd_ir = ir; bus.cmd_data = data; bus.cmd_valid = 1'b1;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; acc_cnt = 0; u0 = udr_cnt;
    @(posedge clk);
    #1;
    if (!hold_valid) bus.cmd_valid = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(posedge clk); n++; #1;
      if (bus.rsp_valid) break;
    end
    bus.cmd_valid = 1'b0;
    chk("latency", 64'(n), 64'd180);
    chk("rsp_data_txn", bus.rsp_data, cap);
    chk("rsp_ir_txn", bus.rsp_ir, irout);
    chk("udr_count", 64'(udr_cnt - u0), 64'd1);
    chk("slave_sr_at_udr", udr_val, data);
    chk("uir_clk", 64'(c_uir), 64'd4);
    chk("cdr_clk", 64'(c_cdr), 64'd4);
    chk("sdr_clk", 64'(c_sdr), 64'd152);
    chk("udr_clk", 64'(c_udr), 64'd4);
    repeat (stall) @(negedge clk);
    chk("rsp_valid_held", bus.rsp_valid, 1'b1);
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    chk("idle_after_hs", {busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
    chk("accepts", 64'(acc_cnt), 64'd1);
  endtask

  initial begin : main
    int u0;
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_rti", {bus.cmd_ready, vjh_rti}, 2'b11);
    chk("rst_zero", {busy, vjh_tck, vjh_tdi, vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, bus.rsp_valid}, 8'h00);

    do_txn(2'b01, 38'h15_DEAD_BEEF, 2'b11, 38'h2A_5A5A_5A5A, 1'b0, 0);
    do_txn(2'b10, 38'h00_1234_5678, 2'b01, 38'h3F_0000_0001, 1'b0, 3);
    do_txn(2'b11, 38'h2A_AAAA_AAAA, 2'b10, 38'h15_5555_5555, 1'b1, 50);

    // Abort a command in SDR bit 20 with TDI high.
    @(negedge clk);
    slave_cap = 38'h0F_0F0F_0F0F; bus.cmd_ir = 2'b01; bus.cmd_data = 38'h3F_FFFF_FFFF;
    bus.cmd_valid = 1'b1; u0 = udr_cnt;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    repeat (88) @(posedge clk);
    #1 chk("pre_abort_sdr_tdi", {vjh_sdr, vjh_tdi}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("abort_ready_rti", {bus.cmd_ready, vjh_rti}, 2'b11);
    chk("abort_zero", {busy, vjh_tck, vjh_tdi, vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, bus.rsp_valid}, 8'h00);
    chk("abort_ir_in", vjh_ir_in, 2'b00);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_udr", 64'(udr_cnt - u0), 64'd0);

    do_txn(2'b00, 38'h01_8000_0001, 2'b00, 38'h20_0000_0003, 1'b0, 0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
